// File: rtl/pwm_capture_if.sv
// Capture-side signal bundle for pwm_capture: control/pulse inputs and measurement outputs.
// master drives the pulse and enable; slave (the capture block) returns the measurements.
interface pwm_capture_if;
    logic        en;
    logic        pwm_in;
    logic [15:0] data;
    logic        valid;
    logic [20:0] period;
    logic        range_err;
    logic        lost;

    modport master (
        output en, pwm_in,
        input  data, valid, period, range_err, lost
    );

    modport slave (
        input  en, pwm_in,
        output data, valid, period, range_err, lost
    );
endinterface

// File: rtl/pwm_capture.sv
// Servo-style PWM pulse-width and period capture with range check and signal-loss detection.
// Widths are measured on a synchronized copy of pwm_in; results strobe out on valid.
module pwm_capture #(
    parameter int MIN_PULSE = 50000,
    parameter int MAX_PULSE = 100000,
    parameter int TIMEOUT   = 1500000
) (
    input  logic         clk,
    input  logic         rst,
    pwm_capture_if.slave bus
);
    typedef enum logic [1:0] {ARM, WAIT_RISE, HIGH} state_t;

    localparam logic [16:0] MIN_C     = 17'(MIN_PULSE);
    localparam logic [16:0] MAX_C     = 17'(MAX_PULSE);
    localparam logic [20:0] TIMEOUT_C = 21'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_s1;
    logic        r_s2;
    logic        r_s2_d;
    logic [1:0]  r_sync_fill;
    logic [16:0] r_high_cnt;
    logic [20:0] r_gap_cnt;
    logic        r_seen;
    logic [15:0] r_data;
    logic        r_valid;
    logic [20:0] r_period;
    logic        r_range_err;
    logic        r_lost;

    logic        w_rise;
    logic        w_fall;
    logic        w_timeout;
    logic        w_start;
    logic        w_capture;
    logic        w_lost_set;
    logic [16:0] w_clip;
    logic [15:0] w_data;
    logic        w_out_of_range;

    assign w_rise    = r_s2 & ~r_s2_d;
    assign w_fall    = ~r_s2 & r_s2_d;
    assign w_timeout = (r_gap_cnt == TIMEOUT_C);

    // ARM only trusts s2 once the synchronizer has refilled after reset,
    // so a pulse already in flight at reset is never taken for a fresh one.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_lost_set   = 1'b0;
        if (!bus.en) begin
            w_state_next = ARM;
        end else begin
            case (r_state)
                ARM: begin
                    if (r_sync_fill[1] && !r_s2) w_state_next = WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (w_timeout) begin
                        w_state_next = ARM;
                        w_lost_set   = 1'b1;
                    end else if (w_rise) begin
                        w_state_next = HIGH;
                        w_start      = 1'b1;
                    end
                end
                HIGH: begin
                    if (w_timeout) begin
                        w_state_next = ARM;
                        w_lost_set   = 1'b1;
                    end else if (w_fall) begin
                        w_state_next = WAIT_RISE;
                        w_capture    = 1'b1;
                    end
                end
                default: w_state_next = ARM;
            endcase
        end
    end

    always_comb begin
        w_out_of_range = (r_high_cnt < MIN_C) || (r_high_cnt > MAX_C);
        if (r_high_cnt < MIN_C)      w_clip = MIN_C;
        else if (r_high_cnt > MAX_C) w_clip = MAX_C;
        else                         w_clip = r_high_cnt;
        w_data = 16'(w_clip - MIN_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ARM;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s2_d      <= 1'b0;
            r_sync_fill <= '0;
            r_high_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_seen      <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_period    <= '0;
            r_range_err <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            r_s1        <= bus.pwm_in;
            r_s2        <= r_s1;
            r_s2_d      <= r_s2;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
            r_state     <= w_state_next;
            r_valid     <= w_capture;

            if (!bus.en) begin
                r_high_cnt <= '0;
                r_gap_cnt  <= '0;
                r_seen     <= 1'b0;
            end else begin
                if (w_rise)                r_gap_cnt <= '0;
                else if (r_gap_cnt != '1)  r_gap_cnt <= r_gap_cnt + 21'd1;

                if (w_start)
                    r_high_cnt <= 17'd1;
                else if (r_state == HIGH && r_s2 && r_high_cnt != '1)
                    r_high_cnt <= r_high_cnt + 17'd1;

                // The first rise after ARM has no valid predecessor, so period holds.
                if (w_start) begin
                    r_seen <= 1'b1;
                    if (r_seen)
                        r_period <= (r_gap_cnt == '1) ? r_gap_cnt : r_gap_cnt + 21'd1;
                end else if (r_state == ARM) begin
                    r_seen <= 1'b0;
                end

                if (w_capture) begin
                    r_data      <= w_data;
                    r_range_err <= w_out_of_range;
                    r_lost      <= 1'b0;
                end else if (w_lost_set) begin
                    r_lost <= 1'b1;
                end
            end
        end
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.period    = r_period;
    assign bus.range_err = r_range_err;
    assign bus.lost      = r_lost;
endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture with scaled-down pulse limits (MIN 50, MAX 100, TIMEOUT 1500).
module tb_pwm_capture;
    typedef struct packed {
        logic [15:0] data;
        logic        err;
        logic [20:0] period;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_rise = 0;
    exp_t sb[$];

    pwm_capture_if bus_if ();

    pwm_capture #(
        .MIN_PULSE(50),
        .MAX_PULSE(100),
        .TIMEOUT  (1500)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int hi, input int lo, input logic [15:0] d,
                         input logic e, input logic [20:0] p);
        exp_t x;
        bus_if.pwm_in = 1'b1;
        last_rise = cyc;
        tick(hi);
        bus_if.pwm_in = 1'b0;
        x.data   = d;
        x.err    = e;
        x.period = p;
        x.cyc    = 32'(cyc + 3);
        sb.push_back(x);
        tick(lo);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_data"},   32'(bus_if.data), 0);
        check({tag, "_period"}, 32'(bus_if.period), 0);
        check({tag, "_valid"},  32'(bus_if.valid), 0);
        check({tag, "_rerr"},   32'(bus_if.range_err), 0);
        check({tag, "_lost"},   32'(bus_if.lost), 0);
    endtask

    always @(negedge clk) begin
        if (bus_if.valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data",    32'(bus_if.data), 32'(e.data));
                check("range_err", 32'(bus_if.range_err), 32'(e.err));
                check("period",  32'(bus_if.period), 32'(e.period));
                check("lost_at_valid", 32'(bus_if.lost), 0);
                check("latency_cycle", 32'(cyc), e.cyc);
            end
        end
    end

    initial begin
        bus_if.en     = 1'b1;
        bus_if.pwm_in = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check_cleared("reset");
        tick(5);

        // nominal 1.5 ms / 20 ms train
        pulse(75, 925, 16'd25, 1'b0, 21'd0);
        pulse(75, 925, 16'd25, 1'b0, 21'd1000);
        pulse(75, 925, 16'd25, 1'b0, 21'd1000);

        // out-of-range and boundary widths
        pulse(25, 975, 16'd0, 1'b1, 21'd1000);
        pulse(125, 875, 16'd50, 1'b1, 21'd1000);
        pulse(50, 950, 16'd0, 1'b0, 21'd1000);
        pulse(49, 951, 16'd0, 1'b1, 21'd1000);
        pulse(100, 900, 16'd50, 1'b0, 21'd1000);
        pulse(101, 899, 16'd50, 1'b1, 21'd1000);

        // signal loss: gap reaches TIMEOUT 1503 cycles after the pwm_in rise
        while (cyc < last_rise + 1503) tick(1);
        check("lost_before_timeout", 32'(bus_if.lost), 0);
        tick(1);
        check("lost_at_timeout", 32'(bus_if.lost), 1);
        check("lost_data_hold", 32'(bus_if.data), 50);
        check("lost_period_hold", 32'(bus_if.period), 1000);
        check("lost_rerr_hold", 32'(bus_if.range_err), 1);
        tick(20);
        pulse(75, 925, 16'd25, 1'b0, 21'd1000);
        check("lost_cleared", 32'(bus_if.lost), 0);

        // input high while reset releases; partial pulse must be dropped
        bus_if.pwm_in = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check_cleared("rst_high");
        tick(40);
        bus_if.pwm_in = 1'b0;
        tick(20);
        pulse(60, 940, 16'd10, 1'b0, 21'd0);
        pulse(60, 940, 16'd10, 1'b0, 21'd1000);

        // one-cycle reset halfway through a pulse
        bus_if.pwm_in = 1'b1;
        tick(37);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_cleared("rst_mid");
        tick(38);
        bus_if.pwm_in = 1'b0;
        tick(925);
        pulse(75, 925, 16'd25, 1'b0, 21'd0);
        pulse(75, 925, 16'd25, 1'b0, 21'd1000);

        // enable dropped mid-pulse
        bus_if.pwm_in = 1'b1;
        tick(37);
        bus_if.en = 1'b0;
        tick(10);
        check("en_data_hold", 32'(bus_if.data), 25);
        check("en_period_hold", 32'(bus_if.period), 1000);
        check("en_rerr_hold", 32'(bus_if.range_err), 0);
        check("en_lost_hold", 32'(bus_if.lost), 0);
        bus_if.en = 1'b1;
        tick(28);
        bus_if.pwm_in = 1'b0;
        tick(925);
        pulse(75, 925, 16'd25, 1'b0, 21'd1000);
        tick(10);

        check("pending_expectations", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
